// File: rtl/vga_seq_pkg.sv
// Shared state encoding and default VGA timing for the pattern sequencer and its helpers.
package vga_seq_pkg;

    typedef enum logic {
        S_PATTERN = 1'b0,
        S_GAME    = 1'b1
    } seq_state_t;

    localparam int DEF_VISIBLE_COLUMNS = 640;
    localparam int DEF_VISIBLE_ROWS    = 480;
    localparam int DEF_TOTAL_COLUMNS   = 800;
    localparam int DEF_TOTAL_ROWS      = 525;

    // Two whole frames without a tick means the counter source has stalled.
    function automatic int wd_limit(input int total_columns, input int total_rows);
        return 2 * total_columns * total_rows;
    endfunction

endpackage

// File: rtl/vga_frame_tick_detect.sv
// Frame tick detector: flags the edge on which the raster enters the first blanking row,
// and registers it as a one-cycle o_FrameTick.
module vga_frame_tick_detect
    import vga_seq_pkg::*;
#(
    parameter int c_VISIBLE_ROWS = DEF_VISIBLE_ROWS
) (
    input  logic       i_Clk,
    input  logic       i_Reset,
    input  logic [9:0] i_ColCount,
    input  logic [9:0] i_RowCount,
    output logic       o_TickNow,
    output logic       o_FrameTick
);

    logic at_tick_pos;
    logic was_at_tick_pos;

    assign at_tick_pos = (i_RowCount == 10'(c_VISIBLE_ROWS)) && (i_ColCount == 10'd0);
    // Only arriving at the position counts, so counters frozen there cannot retrigger.
    assign o_TickNow   = at_tick_pos && !was_at_tick_pos;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            was_at_tick_pos <= 1'b0;
            o_FrameTick     <= 1'b0;
        end else begin
            was_at_tick_pos <= at_tick_pos;
            o_FrameTick     <= o_TickNow;
        end
    end

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Frame-synchronous source/pattern sequencer; all changes land at the start of vertical blanking.
// Optional sync watchdog enabled by defining VGA_SEQ_SYNC_WATCHDOG_EN.
module vga_pattern_sequencer
    import vga_seq_pkg::*;
#(
    parameter int c_PATTERN_SEL_WIDTH  = 4,
    parameter int c_NUM_PATTERNS       = 7,
    parameter int c_FRAMES_PER_PATTERN = 120,
    parameter int c_VISIBLE_COLUMNS    = DEF_VISIBLE_COLUMNS,
    parameter int c_VISIBLE_ROWS       = DEF_VISIBLE_ROWS,
    parameter int c_TOTAL_COLUMNS      = DEF_TOTAL_COLUMNS,
    parameter int c_TOTAL_ROWS         = DEF_TOTAL_ROWS
) (
    input  logic                           i_Clk,
    input  logic                           i_Reset,
    input  logic [9:0]                     i_ColCount,
    input  logic [9:0]                     i_RowCount,
    input  logic                           i_AutoEnable,
    input  logic                           i_NextReq,
    input  logic                           i_GameReq,
    output logic [c_PATTERN_SEL_WIDTH-1:0] o_PatternSelect,
    output logic                           o_SourceGame,
    output logic                           o_FrameTick,
    output logic [7:0]                     o_FrameCount,
    output logic                           o_SyncLost
);

    localparam logic [7:0] LAST_FRAME = 8'(c_FRAMES_PER_PATTERN - 1);

    if (c_FRAMES_PER_PATTERN < 1 || c_NUM_PATTERNS < 1 ||
        c_NUM_PATTERNS > (1 << c_PATTERN_SEL_WIDTH) ||
        c_VISIBLE_COLUMNS >= c_TOTAL_COLUMNS || c_VISIBLE_ROWS >= c_TOTAL_ROWS ||
        c_TOTAL_COLUMNS > 1024 || c_TOTAL_ROWS > 1024) begin : g_bad_params
        $error("vga_pattern_sequencer: inconsistent timing or pattern parameters");
    end

    seq_state_t                     state;
    logic                           next_pending;
    logic                           game_pending;
    logic                           tick_now;
    logic                           service;
    logic [c_PATTERN_SEL_WIDTH-1:0] pattern_next;

    vga_frame_tick_detect #(
        .c_VISIBLE_ROWS (c_VISIBLE_ROWS)
    ) u_tick_detect (
        .i_Clk       (i_Clk),
        .i_Reset     (i_Reset),
        .i_ColCount  (i_ColCount),
        .i_RowCount  (i_RowCount),
        .o_TickNow   (tick_now),
        .o_FrameTick (o_FrameTick)
    );

    assign pattern_next = (o_PatternSelect == c_PATTERN_SEL_WIDTH'(c_NUM_PATTERNS - 1))
                        ? '0 : o_PatternSelect + c_PATTERN_SEL_WIDTH'(1);

`ifdef VGA_SEQ_SYNC_WATCHDOG_EN
    localparam int WD_LIMIT = wd_limit(c_TOTAL_COLUMNS, c_TOTAL_ROWS);
    localparam int WD_WIDTH = $clog2(WD_LIMIT + 1);

    logic [WD_WIDTH-1:0] wd_count;

    always_ff @(posedge i_Clk) begin
        if (i_Reset || tick_now) begin
            wd_count   <= '0;
            o_SyncLost <= 1'b0;
        end else begin
            if (wd_count != WD_WIDTH'(WD_LIMIT))
                wd_count <= wd_count + WD_WIDTH'(1);
            if (wd_count == WD_WIDTH'(WD_LIMIT - 1))
                o_SyncLost <= 1'b1;
        end
    end

    // Without a real tick, pending requests are honoured on every edge.
    assign service = tick_now || o_SyncLost;
`else
    assign o_SyncLost = 1'b0;
    assign service    = tick_now;
`endif

    // NOTE: all branches read the pre-edge pending flags and outputs; non-blocking
    // assignments keep that true even though the same block rewrites them.
    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state           <= S_PATTERN;
            next_pending    <= 1'b0;
            game_pending    <= 1'b0;
            o_PatternSelect <= '0;
            o_SourceGame    <= 1'b0;
            o_FrameCount    <= 8'd0;
        end else if (service) begin
            // Every pending request is consumed here; a pulse on this very edge survives.
            next_pending <= i_NextReq;
            game_pending <= i_GameReq;
            case (state)
                S_PATTERN: begin
                    if (game_pending) begin
                        state        <= S_GAME;
                        o_SourceGame <= 1'b1;
                        o_FrameCount <= 8'd0;
                    end else if (next_pending) begin
                        o_PatternSelect <= pattern_next;
                        o_FrameCount    <= 8'd0;
                    end else if (tick_now && i_AutoEnable) begin
                        if (o_FrameCount == LAST_FRAME) begin
                            o_PatternSelect <= pattern_next;
                            o_FrameCount    <= 8'd0;
                        end else if (o_FrameCount != 8'hFF) begin
                            o_FrameCount <= o_FrameCount + 8'd1;
                        end
                    end
                end
                S_GAME: begin
                    if (game_pending) begin
                        state        <= S_PATTERN;
                        o_SourceGame <= 1'b0;
                        o_FrameCount <= 8'd0;
                    end
                end
                default: state <= S_PATTERN;
            endcase
        end else begin
            next_pending <= next_pending | i_NextReq;
            game_pending <= game_pending | i_GameReq;
        end
    end

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Self-checking bench for vga_pattern_sequencer with a small raster and a frame-level model.
// Watchdog scenarios run when VGA_SEQ_SYNC_WATCHDOG_EN is defined.
module tb_vga_pattern_sequencer;

    localparam int TC       = 8;
    localparam int TR       = 6;
    localparam int VC       = 6;
    localparam int VR       = 4;
    localparam int FPP      = 3;
    localparam int NP       = 7;
    localparam int PW       = 4;
    localparam int FRAME    = TC * TR;
    localparam int WD_LIMIT = 2 * TC * TR;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    col;
    logic [9:0]    row;
    logic          auto_en;
    logic          next_req;
    logic          game_req;
    logic [PW-1:0] pattern_select;
    logic          source_game;
    logic          frame_tick;
    logic [7:0]    frame_count;
    logic          sync_lost;

    int checks   = 0;
    int failures = 0;

    // Reference model state, updated once per clock edge from the sampled inputs.
    int m_pat     = 0;
    int m_fc      = 0;
    int m_since   = 0;
    bit m_game    = 0;
    bit m_tick    = 0;
    bit m_lost    = 0;
    bit m_np      = 0;
    bit m_gp      = 0;
    bit m_prev_at = 0;
    bit running   = 1;

    always #5 clk = ~clk;

    vga_pattern_sequencer #(
        .c_PATTERN_SEL_WIDTH  (PW),
        .c_NUM_PATTERNS       (NP),
        .c_FRAMES_PER_PATTERN (FPP),
        .c_VISIBLE_COLUMNS    (VC),
        .c_VISIBLE_ROWS       (VR),
        .c_TOTAL_COLUMNS      (TC),
        .c_TOTAL_ROWS         (TR)
    ) dut (
        .i_Clk           (clk),
        .i_Reset         (rst),
        .i_ColCount      (col),
        .i_RowCount      (row),
        .i_AutoEnable    (auto_en),
        .i_NextReq       (next_req),
        .i_GameReq       (game_req),
        .o_PatternSelect (pattern_select),
        .o_SourceGame    (source_game),
        .o_FrameTick     (frame_tick),
        .o_FrameCount    (frame_count),
        .o_SyncLost      (sync_lost)
    );

    function automatic string dut_str();
        return $sformatf("pat=%0d game=%0b tick=%0b fc=%0d lost=%0b",
                         pattern_select, source_game, frame_tick, frame_count, sync_lost);
    endfunction

    function automatic string model_str();
        return $sformatf("pat=%0d game=%0b tick=%0b fc=%0d lost=%0b",
                         m_pat, m_game, m_tick, m_fc, m_lost);
    endfunction

    // One clock edge: update the model from the inputs seen at the edge, then
    // (1 time unit later) drop pulses and move the raster counters.
    task automatic clock_edge();
        bit at;
        bit tick;
        bit serve;
        @(posedge clk);
        at = (row == 10'(VR)) && (col == 10'd0);
        if (rst) begin
            m_pat = 0; m_fc = 0; m_game = 0; m_tick = 0; m_lost = 0;
            m_np = 0; m_gp = 0; m_prev_at = 0; m_since = 0;
        end else begin
            tick      = at && !m_prev_at;
            m_prev_at = at;
            serve     = tick || m_lost;
            if (serve) begin
                if (!m_game) begin
                    if (m_gp) begin
                        m_game = 1; m_fc = 0;
                    end else if (m_np) begin
                        m_pat = (m_pat + 1) % NP; m_fc = 0;
                    end else if (tick && auto_en) begin
                        if (m_fc == FPP - 1) begin
                            m_pat = (m_pat + 1) % NP; m_fc = 0;
                        end else if (m_fc < 255) begin
                            m_fc++;
                        end
                    end
                end else if (m_gp) begin
                    m_game = 0; m_fc = 0;
                end
                m_np = next_req;
                m_gp = game_req;
            end else begin
                m_np = m_np | next_req;
                m_gp = m_gp | game_req;
            end
`ifdef VGA_SEQ_SYNC_WATCHDOG_EN
            if (tick) begin
                m_since = 0; m_lost = 0;
            end else begin
                if (m_since < WD_LIMIT) m_since++;
                if (m_since == WD_LIMIT) m_lost = 1;
            end
`endif
            m_tick = tick;
        end
        #1;
        next_req = 1'b0;
        game_req = 1'b0;
        if (running) begin
            if (col == 10'(TC - 1)) begin
                col = 10'd0;
                row = (row == 10'(TR - 1)) ? 10'd0 : row + 10'd1;
            end else begin
                col = col + 10'd1;
            end
        end
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) clock_edge();
    endtask

    task automatic wait_ticks(input int n, input string tag);
        int seen = 0;
        for (int i = 0; i < n * FRAME * 2 + 10 && seen < n; i++) begin
            clock_edge();
            if (m_tick) seen++;
        end
        if (seen < n) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: saw %0d ticks, required %0d", tag, seen, n);
        end
    endtask

    task automatic fresh_reset();
        rst = 1'b1; running = 1; col = 10'd0; row = 10'd0;
        clock_edge();
        rst = 1'b0;
    endtask

    task automatic pulse_next();
        next_req = 1'b1;
        clock_edge();
    endtask

    task automatic pulse_game();
        game_req = 1'b1;
        clock_edge();
    endtask

    task automatic test_reset();
        rst = 1'b1; running = 1; col = 10'd0; row = 10'd0; auto_en = 1'b1;
        run_cycles(2);
        checks++;
        if (pattern_select !== '0) begin failures++; $display("FAIL reset_pattern: got %0d, required 0", pattern_select); end
        checks++;
        if (source_game !== 1'b0) begin failures++; $display("FAIL reset_source: got %0b, required 0", source_game); end
        checks++;
        if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick: got %0b, required 0", frame_tick); end
        checks++;
        if (frame_count !== 8'd0) begin failures++; $display("FAIL reset_count: got %0d, required 0", frame_count); end
        checks++;
        if (sync_lost !== 1'b0) begin failures++; $display("FAIL reset_synclost: got %0b, required 0", sync_lost); end
        rst = 1'b0;
    endtask

    task automatic test_auto_wrap();
        int ticks = 0;
        fresh_reset();
        auto_en = 1'b1;
        for (int i = 0; i < 22 * FRAME && ticks < 21; i++) begin
            clock_edge();
            checks++;
            if ({pattern_select, source_game, frame_tick, frame_count, sync_lost} !==
                {PW'(m_pat), m_game, m_tick, 8'(m_fc), m_lost}) begin
                failures++;
                $display("FAIL auto_wrap cycle %0d: got %s, expected %s", i, dut_str(), model_str());
            end
            if (m_tick) begin
                ticks++;
                checks++;
                if (pattern_select !== PW'((ticks / FPP) % NP) || frame_count !== 8'(ticks % FPP)) begin
                    failures++;
                    $display("FAIL auto_wrap_tick%0d: got pat=%0d fc=%0d, required pat=%0d fc=%0d",
                             ticks, pattern_select, frame_count, (ticks / FPP) % NP, ticks % FPP);
                end
            end
        end
        checks++;
        if (ticks != 21) begin failures++; $display("FAIL auto_wrap_timeout: saw %0d ticks, required 21", ticks); end
    endtask

    task automatic test_manual_next();
        fresh_reset();
        auto_en = 1'b1;
        wait_ticks(7, "manual_setup");
        checks++;
        if (pattern_select !== PW'(2) || frame_count !== 8'd1) begin
            failures++;
            $display("FAIL manual_setup: got pat=%0d fc=%0d, required pat=2 fc=1", pattern_select, frame_count);
        end
        run_cycles(10);
        pulse_next();
        wait_ticks(1, "manual_next");
        checks++;
        if (pattern_select !== PW'(3) || frame_count !== 8'd0 || frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL manual_next: got pat=%0d fc=%0d tick=%0b, required pat=3 fc=0 tick=1",
                     pattern_select, frame_count, frame_tick);
        end
        wait_ticks(1, "manual_after");
        checks++;
        if (pattern_select !== PW'(3) || frame_count !== 8'd1) begin
            failures++;
            $display("FAIL manual_after: got pat=%0d fc=%0d, required pat=3 fc=1", pattern_select, frame_count);
        end
    endtask

    task automatic test_same_edge();
        int p;
        auto_en = 1'b0;
        for (int i = 0; i < 2 * FRAME && !(row == 10'(VR) && col == 10'd0); i++) clock_edge();
        p = m_pat;
        next_req = 1'b1;
        clock_edge();
        checks++;
        if (frame_tick !== 1'b1 || pattern_select !== PW'(p)) begin
            failures++;
            $display("FAIL same_edge_tick: got tick=%0b pat=%0d, required tick=1 pat=%0d", frame_tick, pattern_select, p);
        end
        wait_ticks(1, "same_edge");
        checks++;
        if (pattern_select !== PW'((p + 1) % NP)) begin
            failures++;
            $display("FAIL same_edge_next: got pat=%0d, required %0d", pattern_select, (p + 1) % NP);
        end
    endtask

    task automatic test_game_precedence();
        auto_en = 1'b0;
        for (int i = 0; i < NP && m_pat != 4; i++) begin
            run_cycles(5);
            pulse_next();
            wait_ticks(1, "game_setup");
        end
        run_cycles(5);
        pulse_next();
        pulse_game();
        wait_ticks(1, "game_enter");
        checks++;
        if (source_game !== 1'b1 || pattern_select !== PW'(4) || frame_count !== 8'd0) begin
            failures++;
            $display("FAIL game_enter: got game=%0b pat=%0d fc=%0d, required game=1 pat=4 fc=0",
                     source_game, pattern_select, frame_count);
        end
        run_cycles(5);
        pulse_next();
        wait_ticks(1, "game_next_ignored");
        checks++;
        if (source_game !== 1'b1 || pattern_select !== PW'(4)) begin
            failures++;
            $display("FAIL game_next_ignored: got game=%0b pat=%0d, required game=1 pat=4", source_game, pattern_select);
        end
        run_cycles(5);
        pulse_game();
        wait_ticks(1, "game_exit");
        checks++;
        if (source_game !== 1'b0 || pattern_select !== PW'(4) || frame_count !== 8'd0) begin
            failures++;
            $display("FAIL game_exit: got game=%0b pat=%0d fc=%0d, required game=0 pat=4 fc=0",
                     source_game, pattern_select, frame_count);
        end
        wait_ticks(1, "game_after");
        checks++;
        if (pattern_select !== PW'(4)) begin
            failures++;
            $display("FAIL game_after: got pat=%0d, required 4", pattern_select);
        end
    endtask

    task automatic test_reset_mid();
        auto_en = 1'b0;
        for (int i = 0; i < NP && m_pat != 5; i++) begin
            run_cycles(5);
            pulse_next();
            wait_ticks(1, "reset_mid_setup");
        end
        run_cycles(5);
        pulse_next();
        run_cycles(3);
        rst = 1'b1;
        clock_edge();
        rst = 1'b0;
        checks++;
        if ({pattern_select, source_game, frame_tick, frame_count, sync_lost} !== '0) begin
            failures++;
            $display("FAIL reset_mid: got %s, required all zero", dut_str());
        end
        wait_ticks(1, "reset_mid_tick");
        checks++;
        if (pattern_select !== '0 || frame_count !== 8'd0 || frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_tick: got pat=%0d fc=%0d tick=%0b, required pat=0 fc=0 tick=1",
                     pattern_select, frame_count, frame_tick);
        end
    endtask

    task automatic test_frozen();
        int p;
        int exp_pat;
        int ticks_seen;
        bit exp_lost;
        auto_en = 1'b0;
        wait_ticks(1, "frozen_setup");
        running = 0;
        p = m_pat;
        for (int k = 1; k <= WD_LIMIT + 14; k++) begin
            if (k == 50) next_req = 1'b1;
            clock_edge();
            checks++;
            if ({pattern_select, source_game, frame_tick, frame_count, sync_lost} !==
                {PW'(m_pat), m_game, m_tick, 8'(m_fc), m_lost}) begin
                failures++;
                $display("FAIL frozen cycle %0d: got %s, expected %s", k, dut_str(), model_str());
            end
`ifdef VGA_SEQ_SYNC_WATCHDOG_EN
            exp_lost = (k >= WD_LIMIT);
            exp_pat  = (k >= WD_LIMIT + 1) ? (p + 1) % NP : p;
`else
            exp_lost = 1'b0;
            exp_pat  = p;
`endif
            checks++;
            if (sync_lost !== exp_lost || pattern_select !== PW'(exp_pat) || frame_tick !== 1'b0) begin
                failures++;
                $display("FAIL frozen_rule cycle %0d: got lost=%0b pat=%0d tick=%0b, required lost=%0b pat=%0d tick=0",
                         k, sync_lost, pattern_select, frame_tick, exp_lost, exp_pat);
            end
        end
`ifdef VGA_SEQ_SYNC_WATCHDOG_EN
        pulse_game();
        checks++;
        if (source_game !== 1'b0) begin failures++; $display("FAIL wd_game_latch: got %0b, required 0", source_game); end
        clock_edge();
        checks++;
        if (source_game !== 1'b1) begin failures++; $display("FAIL wd_game_serve: got %0b, required 1", source_game); end
`endif
        running = 1;
        run_cycles(10);
        wait_ticks(1, "frozen_release");
        checks++;
        if (sync_lost !== 1'b0 || frame_tick !== 1'b1) begin
            failures++;
            $display("FAIL frozen_release: got lost=%0b tick=%0b, required lost=0 tick=1", sync_lost, frame_tick);
        end
        run_cycles(5);
        running = 0;
        row = 10'(VR);
        col = 10'd0;
        ticks_seen = 0;
        for (int k = 0; k < 12; k++) begin
            clock_edge();
            if (frame_tick === 1'b1) ticks_seen++;
        end
        checks++;
        if (ticks_seen != 1) begin
            failures++;
            $display("FAIL frozen_at_tick_pos: got %0d ticks, required 1", ticks_seen);
        end
        running = 1;
    endtask

    task automatic test_random();
        running = 1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) auto_en = ~auto_en;
            next_req = ($urandom_range(0, 29) == 0);
            game_req = ($urandom_range(0, 59) == 0);
            rst      = ($urandom_range(0, 499) == 0);
            clock_edge();
            checks++;
            if ({pattern_select, source_game, frame_tick, frame_count, sync_lost} !==
                {PW'(m_pat), m_game, m_tick, 8'(m_fc), m_lost}) begin
                failures++;
                $display("FAIL random cycle %0d: got %s, expected %s", i, dut_str(), model_str());
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish within the time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; auto_en = 1'b0; next_req = 1'b0; game_req = 1'b0;
        col = 10'd0; row = 10'd0;
        test_reset();
        test_auto_wrap();
        test_manual_next();
        test_same_edge();
        test_game_precedence();
        test_reset_mid();
        test_frozen();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
